// File: rtl/accum_drain_ctrl.sv
`default_nettype none
// ============================================================================
// accum_drain_ctrl : drains an accumulator row range to a stream, optionally
//                    zero-clearing each row once its read data has returned
// Rev 1.0
// ============================================================================
module accum_drain_ctrl #(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            base_addr_i,
  input  logic [ADDR_WIDTH:0]              length_i,
  input  logic [NUM_BANKS-1:0]             bank_mask_i,
  input  logic                             clear_en_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             rd_valid_o,
  input  logic                             rd_ready_i,
  output logic [ADDR_WIDTH-1:0]            rd_addr_o,
  output logic [NUM_BANKS-1:0]             rd_mask_o,
  input  logic                             rvalid_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  rdata_i,
  output logic                             wr_valid_o,
  input  logic                             wr_ready_i,
  output logic [ADDR_WIDTH-1:0]            wr_addr_o,
  output logic [NUM_BANKS-1:0]             wr_mask_o,
  output logic                             accum_en_o,
  output logic                             wvalid_o,
  input  logic                             wready_i,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  wdata_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  out_data_o,
  output logic                             out_last_o
);

  localparam int c_row_w = NUM_BANKS * DATA_WIDTH;
  localparam int c_cnt_w = ADDR_WIDTH + 1;
  localparam int c_ptr_w = $clog2(BUF_DEPTH);

  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_buf_depth = c_cnt_w'(BUF_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]   c_fill_one  = (c_ptr_w + 1)'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [c_cnt_w-1:0]      len_q;
  logic [NUM_BANKS-1:0]    mask_q;
  logic                    clr_q;

  logic [c_cnt_w-1:0]      rd_cnt_q;
  logic [c_cnt_w-1:0]      rx_cnt_q;
  logic [c_cnt_w-1:0]      out_cnt_q;
  logic [c_cnt_w-1:0]      wc_cnt_q;
  logic [c_cnt_w-1:0]      wd_cnt_q;

  logic [c_row_w-1:0]      mem_q [BUF_DEPTH];
  logic [c_ptr_w-1:0]      wr_ptr_q;
  logic [c_ptr_w-1:0]      rd_ptr_q;
  logic [c_ptr_w:0]        fill_q;

  logic                    run_w;
  logic [c_cnt_w-1:0]      credit_w;
  logic                    rd_valid_w;
  logic                    rd_fire_w;
  logic                    push_w;
  logic                    out_valid_w;
  logic                    pop_w;
  logic                    wr_valid_w;
  logic                    wr_fire_w;
  logic                    wvalid_w;
  logic                    wd_fire_w;
  logic                    complete_w;

  always_comb begin
    run_w       = (state_q == S_RUN);
    // Rows requested but not yet popped; bounds the unstallable returns in flight.
    credit_w    = rd_cnt_q - out_cnt_q;
    rd_valid_w  = run_w && (rd_cnt_q < len_q) && (credit_w < c_buf_depth);
    rd_fire_w   = rd_valid_w && rd_ready_i;
    push_w      = run_w && rvalid_i;
    out_valid_w = (fill_q != '0);
    pop_w       = out_valid_w && out_ready_i;
    wr_valid_w  = run_w && clr_q && (wc_cnt_q < rx_cnt_q);
    wr_fire_w   = wr_valid_w && wr_ready_i;
    wvalid_w    = run_w && clr_q && (wd_cnt_q < wc_cnt_q);
    wd_fire_w   = wvalid_w && wready_i;
    complete_w  = run_w && (out_cnt_q == len_q) && (!clr_q || (wd_cnt_q == len_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      mask_q    <= '0;
      clr_q     <= 1'b0;
      rd_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      out_cnt_q <= '0;
      wc_cnt_q  <= '0;
      wd_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      done_q <= 1'b0;

      if (rd_fire_w) rd_cnt_q  <= rd_cnt_q + c_cnt_one;
      if (push_w)    rx_cnt_q  <= rx_cnt_q + c_cnt_one;
      if (pop_w)     out_cnt_q <= out_cnt_q + c_cnt_one;
      if (wr_fire_w) wc_cnt_q  <= wc_cnt_q + c_cnt_one;
      if (wd_fire_w) wd_cnt_q  <= wd_cnt_q + c_cnt_one;

      if (push_w) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
      case ({push_w, pop_w})
        2'b10:   fill_q <= fill_q + c_fill_one;
        2'b01:   fill_q <= fill_q - c_fill_one;
        default: fill_q <= fill_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (length_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              base_q    <= base_addr_i;
              len_q     <= length_i;
              mask_q    <= bank_mask_i;
              clr_q     <= clear_en_i;
              rd_cnt_q  <= '0;
              rx_cnt_q  <= '0;
              out_cnt_q <= '0;
              wc_cnt_q  <= '0;
              wd_cnt_q  <= '0;
              wr_ptr_q  <= '0;
              rd_ptr_q  <= '0;
              fill_q    <= '0;
            end
          end
        end
        S_RUN: begin
          if (complete_w) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset; out_data is gated by occupancy so stale rows never leak.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= rdata_i;
  end

  assign busy_o      = (state_q == S_RUN);
  assign done_o      = done_q;
  assign rd_valid_o  = rd_valid_w;
  assign rd_addr_o   = base_q + rd_cnt_q[ADDR_WIDTH-1:0];
  assign rd_mask_o   = mask_q;
  assign wr_valid_o  = wr_valid_w;
  assign wr_addr_o   = base_q + wc_cnt_q[ADDR_WIDTH-1:0];
  assign wr_mask_o   = mask_q;
  assign accum_en_o  = 1'b0;
  assign wvalid_o    = wvalid_w;
  assign wdata_o     = '0;
  assign out_valid_o = out_valid_w;
  assign out_data_o  = out_valid_w ? mem_q[rd_ptr_q] : '0;
  assign out_last_o  = out_valid_w && (out_cnt_q == (len_q - c_cnt_one));

endmodule
`default_nettype wire

// File: tb/tb_accum_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_accum_drain_ctrl : directed bench with a 1-cycle-latency bus slave model
// Rev 1.0
// ============================================================================
module tb_accum_drain_ctrl;

  localparam int NB = 4;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int BD = 4;
  localparam int RW = NB * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [NB-1:0] bank_mask = '0;
  logic          clear_en = 1'b0;
  logic          busy, done;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [AW-1:0] rd_addr;
  logic [NB-1:0] rd_mask;
  logic          rvalid;
  logic [RW-1:0] rdata;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_mask;
  logic          accum_en;
  logic          wvalid;
  logic          wready = 1'b1;
  logic [RW-1:0] wdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_data;
  logic          out_last;

  logic          m_rvalid = 1'b0;
  logic [RW-1:0] m_rdata = '0;
  logic          f_rvalid = 1'b0;
  logic [RW-1:0] f_rdata = '0;
  assign rvalid = m_rvalid | f_rvalid;
  assign rdata  = f_rvalid ? f_rdata : m_rdata;

  accum_drain_ctrl #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .start_i(start), .base_addr_i(base_addr), .length_i(length),
    .bank_mask_i(bank_mask), .clear_en_i(clear_en),
    .busy_o(busy), .done_o(done),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_addr_o(rd_addr), .rd_mask_o(rd_mask),
    .rvalid_i(rvalid), .rdata_i(rdata),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_addr_o(wr_addr), .wr_mask_o(wr_mask), .accum_en_o(accum_en),
    .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  // Row contents are a function of the address so every beat is identifiable.
  function automatic logic [RW-1:0] row(input logic [AW-1:0] a);
    logic [RW-1:0] r;
    r = '0;
    for (int l = 0; l < NB; l++) r[l*DW +: DW] = (64'(l + 1) << 56) | 64'(a);
    return r;
  endfunction

  always @(posedge clk) begin
    m_rvalid <= rd_valid && rd_ready;
    m_rdata  <= row(rd_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] rd_q[$];
  int            rd_cyc[$];
  logic [RW-1:0] out_q[$];
  logic          last_q[$];
  int            out_cyc[$];
  logic [AW-1:0] wr_q[$];
  int            wd_n, wd_last_cyc, done_n, done_cyc, rv_n;
  bit            order_bad, accum_bad, wdata_bad, mask_bad, credit_bad;
  logic [NB-1:0] exp_mask;

  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      rd_q.push_back(rd_addr);
      rd_cyc.push_back(cyc);
      if (rd_mask !== exp_mask) mask_bad = 1'b1;
    end
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
      out_cyc.push_back(cyc);
    end
    if (wr_valid && wr_ready) begin
      if (rv_n <= wr_q.size()) order_bad = 1'b1;
      if (accum_en !== 1'b0) accum_bad = 1'b1;
      if (wr_mask !== exp_mask) mask_bad = 1'b1;
      wr_q.push_back(wr_addr);
    end
    if (wvalid && wready) begin
      if (wdata !== '0) wdata_bad = 1'b1;
      wd_n++;
      wd_last_cyc = cyc;
    end
    if (rvalid && busy) rv_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if ((rd_q.size() - out_q.size()) > BD) credit_bad = 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs(input logic [NB-1:0] m);
    rd_q.delete(); rd_cyc.delete(); out_q.delete(); last_q.delete(); out_cyc.delete();
    wr_q.delete();
    wd_n = 0; wd_last_cyc = 0; done_n = 0; done_cyc = 0; rv_n = 0;
    order_bad = 0; accum_bad = 0; wdata_bad = 0; mask_bad = 0; credit_bad = 0;
    exp_mask = m;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] len,
                        input logic [NB-1:0] m, input logic c);
    clear_logs(m);
    base_addr = b; length = len; bank_mask = m; clear_en = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done_n == 0 && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, RW'(done_n != 0), RW'(1));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ctrl"}, RW'({busy, done, rd_valid, wr_valid, wvalid, out_valid, out_last, accum_en}), '0);
    chk({tag, "_addr"}, RW'({rd_addr, rd_mask, wr_addr, wr_mask}), '0);
    chk({tag, "_wdata"}, wdata, '0);
    chk({tag, "_odata"}, out_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    clear_logs('0);
    tick(); tick(); tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Plain 4-row burst, everything ready
    launch(9'h010, 10'd4, 4'hF, 1'b0);
    chk("t1_busy_rdv", RW'({busy, rd_valid}), RW'(2'b11));
    wait_done("t1_done_timeout", 40);
    tick(); tick(); tick();
    chk("t1_done_once", RW'(done_n), RW'(1));
    chk("t1_busy_after", RW'(busy), RW'(0));
    chk("t1_rd_count", RW'(rd_q.size()), RW'(4));
    for (int i = 0; i < 4; i++) chk("t1_rd_addr", RW'(rd_q[i]), RW'(9'h010 + 9'(i)));
    chk("t1_rd_consec", RW'(rd_cyc[3] - rd_cyc[0]), RW'(3));
    chk("t1_out_count", RW'(out_q.size()), RW'(4));
    for (int i = 0; i < 4; i++) chk("t1_out_data", out_q[i], row(9'h010 + 9'(i)));
    chk("t1_out_last", RW'({last_q[0], last_q[1], last_q[2], last_q[3]}), RW'(4'b0001));
    chk("t1_out_consec", RW'(out_cyc[3] - out_cyc[0]), RW'(3));
    chk("t1_no_writes", RW'(wr_q.size() + wd_n), RW'(0));
    chk("t1_mask", RW'(mask_bad), RW'(0));

    // Backpressure: a longer burst shows the read credit stopping at BUF_DEPTH
    out_ready = 1'b0;
    launch(9'h010, 10'd8, 4'hF, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("t2_rd_stalled_count", RW'(rd_q.size()), RW'(BD));
    chk("t2_rd_valid_low", RW'(rd_valid), RW'(0));
    chk("t2_out_held", RW'({out_valid, busy}), RW'(2'b11));
    out_ready = 1'b1;
    wait_done("t2_done_timeout", 60);
    chk("t2_out_count", RW'(out_q.size()), RW'(8));
    for (int i = 0; i < 8; i++) chk("t2_out_data", out_q[i], row(9'h010 + 9'(i)));
    chk("t2_last", RW'({last_q[6], last_q[7]}), RW'(2'b01));
    chk("t2_credit", RW'(credit_bad), RW'(0));
    tick();

    // Clear path across the address wrap, partial mask
    launch(9'h1FE, 10'd4, 4'h5, 1'b1);
    wait_done("t3_done_timeout", 60);
    chk("t3_rd_count", RW'(rd_q.size()), RW'(4));
    chk("t3_wr_count", RW'(wr_q.size()), RW'(4));
    chk("t3_rd_addr", RW'({rd_q[0], rd_q[1], rd_q[2], rd_q[3]}), RW'({9'h1FE, 9'h1FF, 9'h000, 9'h001}));
    chk("t3_wr_addr", RW'({wr_q[0], wr_q[1], wr_q[2], wr_q[3]}), RW'({9'h1FE, 9'h1FF, 9'h000, 9'h001}));
    chk("t3_wd_count", RW'(wd_n), RW'(4));
    chk("t3_done_after_wd", RW'(done_cyc - wd_last_cyc), RW'(2));
    chk("t3_flags", RW'({order_bad, accum_bad, wdata_bad, mask_bad}), RW'(0));
    chk("t3_out_data", out_q[2], row(9'h000));
    tick();

    // Write data channel blocked: burst cannot complete
    wready = 1'b0;
    launch(9'h040, 10'd2, 4'hF, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_stuck", RW'({busy, done_n == 0}), RW'(2'b11));
    chk("t4_counts", RW'({wr_q.size() == 2, out_q.size() == 2, wd_n == 0}), RW'(3'b111));
    chk("t4_wr_addr", RW'({wr_q[0], wr_q[1]}), RW'({9'h040, 9'h041}));
    wready = 1'b1;
    wait_done("t4_done_timeout", 20);
    chk("t4_wd_count", RW'(wd_n), RW'(2));
    tick();

    // Zero-length launch
    launch(9'h033, 10'd0, 4'hF, 1'b1);
    chk("t5_done_next", RW'({done, busy}), RW'(2'b10));
    tick();
    chk("t5_done_pulse_end", RW'({done, busy}), RW'(2'b00));
    tick(); tick();
    chk("t5_no_traffic", RW'(rd_q.size() + wr_q.size() + wd_n + out_q.size()), RW'(0));
    chk("t5_done_once", RW'(done_n), RW'(1));

    // Reset mid-burst, stray returns, then a fresh single-row burst
    launch(9'h080, 10'd8, 4'hF, 1'b0);
    begin
      int n = 0;
      while (out_q.size() < 2 && n < 40) begin tick(); n++; end
    end
    chk("t6_two_rows", RW'(out_q.size() >= 2), RW'(1));
    done_n = 0;
    rst = 1'b1;
    tick();
    check_idle_zero("t6_reset");
    rst = 1'b0;
    f_rvalid = 1'b1;
    f_rdata = {RW{1'b1}};
    tick(); tick(); tick();
    f_rvalid = 1'b0;
    tick();
    chk("t6_stray_dropped", RW'({out_valid, busy}), RW'(0));
    chk("t6_no_done", RW'(done_n), RW'(0));
    launch(9'h005, 10'd1, 4'hF, 1'b0);
    wait_done("t6_done_timeout", 20);
    chk("t6_out_count", RW'(out_q.size()), RW'(1));
    chk("t6_out_data", out_q[0], row(9'h005));
    chk("t6_out_last", RW'(last_q[0]), RW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
